s444_config_loader: RTL and testbench

//   Configuration sequencer for a chain of S444 logic cells. Accepts config bytes

---
 rtl/s444_config_loader.sv | 222 ++++++++++++++++++++++
 tb/tb_s444_config_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/s444_config_loader.sv
// -----------------------------------------------------------------------------
// s444_config_loader
//   Configuration sequencer for a chain of S444 logic cells. Config bytes come
//   in over a valid/ready stream and are serialised LSB-first into the cell
//   shift chain. The chain is held still whenever no data is buffered.
//
//   Optional feature macro: CFG_CRC_CHECK_EN
//     When defined, a CRC-8 (poly 0x07, init 0x00) is accumulated over every
//     shifted bit. After the last bit, one trailer byte is compared with it and
//     a mismatch raises error.
//
// Parameters
//   CHAIN_LEN       total config bits in the cell chain (>= 1)
//   CNT_W           width of the remaining-bit counter (derived)
//
// Ports
//   clock           rising-edge clock
//   reset_n         asynchronous active-low reset
//   start           pulse: begin a load (honoured only in IDLE or DONE)
//   abort           pulse: cancel anything and return to IDLE (wins over start)
//   in_data         config byte, bit 0 shifted first
//   in_valid        in_data valid
//   in_ready        loader accepts in_data this cycle
//   cfg_shift_en    chain enable; chain shifts when 1
//   cfg_shift_data  shift_in of the first cell
//   busy            load in progress (LOAD or CHECK)
//   done            load finished, held until start/abort
//   error           CRC mismatch, held until start/abort (0 without CRC)
// -----------------------------------------------------------------------------
module s444_config_loader #(
    parameter  int CHAIN_LEN = 32,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       cfg_shift_en,
    output logic       cfg_shift_data,
    output logic       busy,
    output logic       done,
    output logic       error
);

    // Common width for comparing the remaining counter with the buffer count.
    localparam int CMP_W = (CNT_W > 4) ? CNT_W : 4;
    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic [7:0]       buf_r, buf_s;
    logic [3:0]       bufcnt_r, bufcnt_s;
    logic [CNT_W-1:0] remaining_r, remaining_s;

    logic             shift_en_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [CMP_W-1:0] rem_ext_s;
    logic [CMP_W-1:0] cnt_ext_s;
    logic [CMP_W-1:0] avail_s;
    logic [3:0]       load_cnt_s;

`ifdef CFG_CRC_CHECK_EN
    logic [7:0] crc_r, crc_s;
    logic       error_r, error_s;

    // One CRC-8 step, MSB-first register, polynomial 0x07.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`endif

    // Handshake and shift qualifiers derived from registered state only.
    always_comb begin
        rem_ext_s  = CMP_W'(remaining_r);
        cnt_ext_s  = CMP_W'(bufcnt_r);
        shift_en_s = (state_r == ST_LOAD) && (bufcnt_r != 4'd0);
        // Bits still owed to the chain that are not already buffered.
        avail_s    = rem_ext_s - cnt_ext_s;
        load_cnt_s = (avail_s >= CMP_W'(8)) ? 4'd8 : avail_s[3:0];
        if (state_r == ST_LOAD) begin
            // Refill when empty, or on the last buffered bit for gap-free shifting.
            in_ready_s = (rem_ext_s > cnt_ext_s) &&
                         ((bufcnt_r == 4'd0) || ((bufcnt_r == 4'd1) && shift_en_s));
        end else if (state_r == ST_CHECK) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = in_valid && in_ready_s;
    end

    // Next-state and datapath update.
    always_comb begin
        state_s     = state_r;
        buf_s       = buf_r;
        bufcnt_s    = bufcnt_r;
        remaining_s = remaining_r;
`ifdef CFG_CRC_CHECK_EN
        crc_s       = crc_r;
        error_s     = error_r;
`endif
        if (abort) begin
            // Flush the buffer; the partially loaded chain is left as-is.
            state_s     = ST_IDLE;
            buf_s       = 8'h00;
            bufcnt_s    = 4'd0;
            remaining_s = CHAIN_LEN_C;
`ifdef CFG_CRC_CHECK_EN
            crc_s       = 8'h00;
            error_s     = 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_s     = ST_LOAD;
                        buf_s       = 8'h00;
                        bufcnt_s    = 4'd0;
                        remaining_s = CHAIN_LEN_C;
`ifdef CFG_CRC_CHECK_EN
                        crc_s       = 8'h00;
                        error_s     = 1'b0;
`endif
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_LOAD: begin
                    if (shift_en_s) begin
                        buf_s       = {1'b0, buf_r[7:1]};
                        bufcnt_s    = bufcnt_r - 4'd1;
                        remaining_s = remaining_r - CNT_W'(1);
`ifdef CFG_CRC_CHECK_EN
                        crc_s       = crc8_step(crc_r, buf_r[0]);
`endif
                        if (remaining_r == CNT_W'(1)) begin
`ifdef CFG_CRC_CHECK_EN
                            state_s = ST_CHECK;
`else
                            state_s = ST_DONE;
`endif
                        end else begin
                            state_s = ST_LOAD;
                        end
                    end else begin
                        state_s = ST_LOAD;
                    end
                    // A new byte overrides the (now empty) buffer; excess high
                    // bits of the final byte are never counted, so never shifted.
                    if (accept_s) begin
                        buf_s    = in_data;
                        bufcnt_s = load_cnt_s;
                    end else begin
                        buf_s = buf_s;
                    end
                end
                ST_CHECK: begin
`ifdef CFG_CRC_CHECK_EN
                    if (in_valid) begin
                        error_s = (in_data != crc_r);
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_CHECK;
                    end
`else
                    state_s = ST_IDLE;
`endif
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            buf_r       <= 8'h00;
            bufcnt_r    <= 4'd0;
            remaining_r <= CHAIN_LEN_C;
`ifdef CFG_CRC_CHECK_EN
            crc_r       <= 8'h00;
            error_r     <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            buf_r       <= buf_s;
            bufcnt_r    <= bufcnt_s;
            remaining_r <= remaining_s;
`ifdef CFG_CRC_CHECK_EN
            crc_r       <= crc_s;
            error_r     <= error_s;
`endif
        end
    end

    assign in_ready       = in_ready_s;
    assign cfg_shift_en   = shift_en_s;
    assign cfg_shift_data = shift_en_s & buf_r[0];
    assign busy           = (state_r == ST_LOAD) || (state_r == ST_CHECK);
    assign done           = (state_r == ST_DONE);
`ifdef CFG_CRC_CHECK_EN
    assign error          = error_r;
`else
    assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_s444_config_loader.sv
// -----------------------------------------------------------------------------
// tb_s444_config_loader
//   Randomised scoreboard bench. Each load pushes the chain bit sequence it
//   should produce (first CHAIN_LEN bits of the byte image, LSB-first) into a
//   queue; an independent monitor pops one bit per enabled shift cycle.
//   Honours CFG_CRC_CHECK_EN (trailer byte, error flag) when defined.
// -----------------------------------------------------------------------------
module tb_s444_config_loader;

    localparam int CL = 20;
    localparam int NB = (CL + 7) / 8;

    logic       clock    = 1'b0;
    logic       reset_n  = 1'b0;
    logic       start    = 1'b0;
    logic       abort    = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       cfg_shift_en;
    logic       cfg_shift_data;
    logic       busy;
    logic       done;
    logic       error;

    int  checks = 0;
    int  errors = 0;
    bit  exp_q[$];
    int  total_shifts = 0;
    bit  chk_done_next = 1'b0;
    bit  extra_phase = 1'b0;

    always #5 clock = ~clock;

    s444_config_loader #(.CHAIN_LEN(CL)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .cfg_shift_en   (cfg_shift_en),
        .cfg_shift_data (cfg_shift_data),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [8*NB-1:0] rand_data();
        logic [8*NB-1:0] r;
        for (int i = 0; i < NB; i++) r[8*i +: 8] = 8'($urandom_range(255));
        return r;
    endfunction

    // Monitor: consumes one expected bit for every enabled shift cycle.
    always @(negedge clock) begin
        if (reset_n) begin
`ifndef CFG_CRC_CHECK_EN
            if (chk_done_next) begin
                check("done_after_last_bit", done, 1);
                check("busy_after_last_bit", busy, 0);
                chk_done_next = 1'b0;
            end
`endif
            if (cfg_shift_en) begin
                total_shifts++;
                check("no_extra_shift", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("shift_data", cfg_shift_data, exp_q.pop_front());
`ifndef CFG_CRC_CHECK_EN
                    if (exp_q.size() == 0) chk_done_next = 1'b1;
`endif
                end
            end else begin
                check("data_zero_when_idle", cfg_shift_data, 0);
            end
            if (extra_phase && in_valid) check("no_extra_accept", in_ready, 0);
        end
    end

    // Runs one load. Called and returns just after a rising edge.
    task automatic do_load(input logic [8*NB-1:0] data, input int gap_pct,
                           input bit poke_start, input int abort_after, input bit bad_trailer);
        logic [7:0] bytes_q[$];
        logic [7:0] crc;
        int  idx, cycles, base;
        bit  acc, aborted, exp_err, fb;
        exp_q.delete();
        crc = 8'h00;
        for (int i = 0; i < CL; i++) begin
            exp_q.push_back(data[i]);
            fb  = crc[7] ^ data[i];
            crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        for (int i = 0; i < NB; i++) bytes_q.push_back(data[8*i +: 8]);
        exp_err = 1'b0;
`ifdef CFG_CRC_CHECK_EN
        bytes_q.push_back(bad_trailer ? (crc ^ 8'h5A) : crc);
        exp_err = bad_trailer;
`endif
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        idx = 0; cycles = 0; base = total_shifts; aborted = 1'b0;
        while (done !== 1'b1 && cycles < 500 && !aborted) begin
            if (idx < bytes_q.size()) begin
                in_valid = ($urandom_range(99) >= gap_pct);
                in_data  = bytes_q[idx];
            end else begin
                extra_phase = 1'b1;
                in_valid    = 1'b1;
                in_data     = 8'hC3;
            end
            start = poke_start && (cycles == 5);
            abort = (abort_after >= 0) && (total_shifts - base >= abort_after);
            @(negedge clock);
            if (cycles == 0) begin
                check("busy_after_start", busy, 1);
                check("done_clear_after_start", done, 0);
            end
            acc = in_valid && in_ready;
            @(posedge clock); #1;
            if (acc) idx++;
            if (abort) begin
                abort   = 1'b0;
                aborted = 1'b1;
                exp_q.delete();
            end
            start = 1'b0;
            cycles++;
        end
        in_valid = 1'b0; in_data = 8'h00; extra_phase = 1'b0;
        if (aborted) begin
            @(negedge clock);
            check("abort_busy", busy, 0);
            check("abort_shift_en", cfg_shift_en, 0);
            check("abort_in_ready", in_ready, 0);
            check("abort_done", done, 0);
            @(posedge clock); #1;
        end else begin
            check("load_timeout", cycles < 500, 1);
            check("bits_left_unshifted", exp_q.size(), 0);
            check("error_flag", error, exp_err);
`ifndef CFG_CRC_CHECK_EN
            if (gap_pct == 0 && !poke_start) check("gapfree_latency", cycles, CL + 1);
`endif
        end
    endtask

    initial begin
        logic [7:0] b;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_shift_en", cfg_shift_en, 0);
        check("rst_in_ready", in_ready, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_in_ready", in_ready, 0);
        check("idle_busy", busy, 0);
        @(posedge clock); #1;

        // Directed: 0xFF then 0xA5, final byte only partly used.
        do_load({8'h3C, 8'hA5, 8'hFF}, 0, 1'b0, -1, 1'b0);
        // Randomised loads with input gaps.
        for (int n = 0; n < 4; n++) do_load(rand_data(), 30, 1'b0, -1, 1'($urandom_range(1)));
        // start during LOAD must be ignored.
        do_load(rand_data(), 0, 1'b1, -1, 1'b0);
        // Abort after 10 bits, then a full reload.
        do_load(rand_data(), 0, 1'b0, 10, 1'b0);
        do_load(rand_data(), 20, 1'b0, -1, 1'b1);

        // start and abort together: abort wins.
        start = 1'b1; abort = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clock);
        check("start_abort_busy", busy, 0);
        check("start_abort_done", done, 0);
        check("start_abort_in_ready", in_ready, 0);
        @(posedge clock); #1;

        // Asynchronous reset mid-load.
        b = 8'($urandom_range(255));
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; in_valid = 1'b1; in_data = b;
        repeat (4) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_reset_busy", busy, 0);
        check("mid_reset_shift_en", cfg_shift_en, 0);
        check("mid_reset_in_ready", in_ready, 0);
        in_valid = 1'b0; in_data = 8'h00;
        exp_q.delete();
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        do_load(rand_data(), 10, 1'b0, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
